// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch (I) and load/store (D).
// Optional macro ARB_TIMEOUT_EN aborts a stalled memory request after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_ack,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     ls_req,
  input  logic                     ls_we,
  input  logic [ADDRESS_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0]    ls_wdata,
  output logic                     ls_ack,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     mem_err,
  output logic                     owner,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic                     if_ack_n, ls_ack_n;
  logic [DATA_WIDTH-1:0]    if_rdata_n, ls_rdata_n;
  logic                     mem_req_n, mem_we_n;
  logic [ADDRESS_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0]    mem_wdata_n;
  logic                     owner_n, busy_n;

  logic elig_i, elig_d, gnt_i, gnt_d;
  logic abort, done;
  logic [DATA_WIDTH-1:0] ret;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt, wcnt_n;
`endif

  always_comb begin
    // a requester still seeing its ack holds a stale req; don't re-grant it
    elig_i = if_req & ~if_ack;
    elig_d = ls_req & ~ls_ack;
    gnt_d  = elig_d & ~(elig_i & (cnt == LIM));
    gnt_i  = elig_i & ~gnt_d;

    abort = 1'b0;
`ifdef ARB_TIMEOUT_EN
    abort = (state != IDLE) & ~mem_ready &
            (wcnt == TW'(TIMEOUT_CYCLES - 1));
`endif
    done = (state != IDLE) & (mem_ready | abort);
    ret  = (abort | ((state == BUSY_D) & mem_we)) ?
           '0 : mem_rdata;

    state_n     = state;
    cnt_n       = cnt;
    if_ack_n    = 1'b0;
    ls_ack_n    = 1'b0;
    if_rdata_n  = if_rdata;
    ls_rdata_n  = ls_rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    owner_n     = owner;
    busy_n      = busy;
`ifdef ARB_TIMEOUT_EN
    wcnt_n      = wcnt;
`endif

    unique case (state)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        wcnt_n = '0;
`endif
        unique case (1'b1)
          gnt_d: begin
            state_n     = BUSY_D;
            mem_req_n   = 1'b1;
            mem_we_n    = ls_we;
            mem_addr_n  = ls_addr;
            mem_wdata_n = ls_wdata;
            owner_n     = 1'b1;
            busy_n      = 1'b1;
            cnt_n       = ~if_req ? 4'd0 :
                          (cnt == LIM) ? cnt : cnt + 4'd1;
          end
          gnt_i: begin
            state_n     = BUSY_I;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b0;
            mem_addr_n  = if_addr;
            mem_wdata_n = '0;
            owner_n     = 1'b0;
            busy_n      = 1'b1;
            cnt_n       = 4'd0;
          end
          default: ;
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          busy_n    = 1'b0;
          if (state == BUSY_D) begin
            ls_ack_n   = 1'b1;
            ls_rdata_n = ret;
          end else begin
            if_ack_n   = 1'b1;
            if_rdata_n = ret;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          wcnt_n = wcnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if_ack    <= if_ack_n;
      ls_ack    <= ls_ack_n;
      if_rdata  <= if_rdata_n;
      ls_rdata  <= ls_rdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      owner     <= owner_n;
      busy      <= busy_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      wcnt    <= wcnt_n;
      mem_err <= abort;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIM = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic if_req, ls_req, ls_we, mem_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;
  logic if_ack, ls_ack, mem_req, mem_we, mem_err, owner, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference model state
  bit e_if_ack, e_ls_ack, e_err, e_req, e_we, e_owner, e_busy;
  logic [DW-1:0] e_if_rdata, e_ls_rdata, e_wdata;
  logic [AW-1:0] e_addr;
  int m_who, m_cnt, m_wait;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    tick();
    tick();
    rst = 1;
    m_who = -1; m_cnt = 0; m_wait = 0;
    e_if_ack = 0; e_ls_ack = 0; e_err = 0; e_req = 0;
    e_we = 0; e_owner = 0; e_busy = 0;
    e_if_rdata = '0; e_ls_rdata = '0; e_wdata = '0; e_addr = '0;
  endtask

  task automatic model_finish(input logic [DW-1:0] v);
    e_req = 0; e_busy = 0; e_we = 0;
    if (m_who == 1) begin e_ls_ack = 1; e_ls_rdata = v; end
    else begin e_if_ack = 1; e_if_rdata = v; end
    m_who = -1;
  endtask

  // one clock of the arbitration rules, using inputs as sampled at the edge
  task automatic model_step();
    bit pi, pd, was_we;
    pi = if_req && !e_if_ack;
    pd = ls_req && !e_ls_ack;
    e_if_ack = 0; e_ls_ack = 0; e_err = 0;
    if (m_who < 0) begin
      if (pd && !(pi && m_cnt == LIM)) begin
        e_req = 1; e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata;
        e_owner = 1; e_busy = 1; m_who = 1; m_wait = 0;
        m_cnt = !if_req ? 0 : (m_cnt < LIM ? m_cnt + 1 : LIM);
      end else if (pi) begin
        e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = '0;
        e_owner = 0; e_busy = 1; m_who = 0; m_wait = 0;
        m_cnt = 0;
      end
    end else if (mem_ready) begin
      was_we = e_we;
      model_finish((m_who == 1 && was_we) ? '0 : mem_rdata);
    end else begin
      m_wait++;
`ifdef ARB_TIMEOUT_EN
      if (m_wait == TO) begin
        model_finish('0);
        e_err = 1;
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    if_req = 1; ls_req = 1; ls_we = 1;
    if_addr = 32'h20; ls_addr = 32'h44; ls_wdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({if_ack, if_rdata, ls_ack, ls_rdata, mem_req, mem_we,
           mem_addr, mem_wdata, mem_err, owner, busy} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d req=%b busy=%b addr=%h want all 0",
                 i, mem_req, busy, mem_addr);
      end
    end
    rst = 1;
    tick();
    total++;
    if ({mem_req, owner, busy, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h55}) begin
      bad++;
      $display("FAIL reset_first_grant req=%b own=%b busy=%b we=%b addr=%h wd=%h want 1 1 1 1 44 55",
               mem_req, owner, busy, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_fetch();
    int pulses;
    do_reset();
    if_req = 1; if_addr = 32'h10;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    total++;
    if ({mem_req, mem_we, owner, busy, if_ack, mem_addr} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10}) begin
      bad++;
      $display("FAIL fetch_grant req=%b we=%b own=%b busy=%b ack=%b addr=%h want 1 0 0 1 0 10",
               mem_req, mem_we, owner, busy, if_ack, mem_addr);
    end
    tick();
    total++;
    if ({if_ack, ls_ack, mem_req, busy, if_rdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL fetch_ack ack=%b lsack=%b req=%b busy=%b rd=%h want 1 0 0 0 deadbeef",
               if_ack, ls_ack, mem_req, busy, if_rdata);
    end
    if_req = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(if_ack);
    end
    total++;
    if (pulses != 0 || if_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL fetch_single_pulse extra=%0d rd=%h want 0 deadbeef",
               pulses, if_rdata);
    end
  endtask

  task automatic test_store_wait();
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h1234;
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      ls_addr = 32'h99; ls_wdata = 32'h7777; ls_we = 0;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, owner, ls_ack} !==
          {1'b1, 1'b1, 32'h40, 32'h1234, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL store_hold cyc=%0d req=%b we=%b addr=%h wd=%h own=%b ack=%b",
                 i, mem_req, mem_we, mem_addr, mem_wdata, owner, ls_ack);
      end
    end
    mem_ready = 1;
    tick();
    ls_req = 0;
    total++;
    if ({ls_ack, if_ack, ls_rdata, mem_req, mem_we, busy} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL store_ack ack=%b ifack=%b rd=%h req=%b we=%b busy=%b want 1 0 0 0 0 0",
               ls_ack, if_ack, ls_rdata, mem_req, mem_we, busy);
    end
  endtask

  task automatic test_starvation();
    bit want[6] = '{1, 1, 1, 1, 0, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if_req = 1; ls_req = 1; ls_we = 0; mem_ready = 0;
      tick();
      total++;
      if (mem_req !== 1'b1 || owner !== want[k]) begin
        bad++;
        $display("FAIL starve_order grant=%0d req=%b owner=%b want 1 %b",
                 k, mem_req, owner, want[k]);
      end
      if_req = 0; ls_req = 0; mem_ready = 1;
      tick();
      mem_ready = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ls_req = 1; ls_addr = 32'h80;
    tick();
    tick();
    rst = 0;
    tick();
    total++;
    if ({mem_req, busy, ls_ack, owner, mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_mid req=%b busy=%b ack=%b own=%b addr=%h want all 0",
               mem_req, busy, ls_ack, owner, mem_addr);
    end
    rst = 1; ls_req = 0; mem_ready = 1;
    tick();
    tick();
    total++;
    if ({mem_req, busy, ls_ack, if_ack} !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_after req=%b busy=%b lsack=%b ifack=%b want 0",
               mem_req, busy, ls_ack, if_ack);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    if_req = 1; if_addr = 32'h30; mem_rdata = 32'hA5A5A5A5;
    tick();
    if_req = 0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) tick();
    total++;
    if ({mem_req, if_ack, mem_err} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_early req=%b ack=%b err=%b want 1 0 0",
               mem_req, if_ack, mem_err);
    end
    tick();
    total++;
    if ({mem_req, if_ack, mem_err, if_rdata} !== {3'b011, 32'h0}) begin
      bad++;
      $display("FAIL timeout_fire req=%b ack=%b err=%b rd=%h want 0 1 1 0",
               mem_req, if_ack, mem_err, if_rdata);
    end
    tick();
    total++;
    if ({mem_err, if_ack} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_pulse err=%b ack=%b want 0 0", mem_err, if_ack);
    end
`else
    for (int i = 0; i < 100; i++) tick();
    total++;
    if ({mem_req, busy, if_ack, mem_err, mem_addr} !== {4'b1100, 32'h30}) begin
      bad++;
      $display("FAIL no_timeout req=%b busy=%b ack=%b err=%b addr=%h want 1 1 0 0 30",
               mem_req, busy, if_ack, mem_err, mem_addr);
    end
`endif
  endtask

  task automatic test_random();
    logic [199:0] got, exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if_req = ($urandom_range(0, 3) != 0);
      ls_req = ($urandom_range(0, 3) != 0);
      ls_we = 1'($urandom);
      if_addr = $urandom; ls_addr = $urandom;
      ls_wdata = $urandom; mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      model_step();
      tick();
      got = 200'({if_ack, ls_ack, mem_req, mem_we, mem_err, owner, busy,
                  if_rdata, ls_rdata, mem_addr, mem_wdata});
      exp = 200'({e_if_ack, e_ls_ack, e_req, e_we, e_err, e_owner, e_busy,
                  e_if_rdata, e_ls_rdata, e_addr, e_wdata});
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_starvation();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
